// File: rtl/mem_lsu_if.sv
// Bundle between the memory-stage LSU, the pipeline that feeds it and the
// byte-wide RAM port. The slave modport is the LSU side, the master modport is its environment.
interface mem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid_i;
    logic              ready_o;
    logic [3:0]        memop_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       sdata_i;
    logic [4:0]        wd_i;
    logic              wreg_i;
    logic [31:0]       wdata_i;
    logic              out_valid_o;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [31:0]       wdata_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic              mem_wr_o;
    logic [7:0]        mem_dout_o;
    logic [7:0]        mem_din_i;

    modport master (
        output in_valid_i, memop_i, addr_i, sdata_i, wd_i, wreg_i, wdata_i, mem_din_i,
        input  ready_o, out_valid_o, wd_o, wreg_o, wdata_o, mem_a_o, mem_wr_o, mem_dout_o
    );

    modport slave (
        input  in_valid_i, memop_i, addr_i, sdata_i, wd_i, wreg_i, wdata_i, mem_din_i,
        output ready_o, out_valid_o, wd_o, wreg_o, wdata_o, mem_a_o, mem_wr_o, mem_dout_o
    );
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: moves 1/2/4 bytes little-endian over an 8-bit
// RAM port and returns the write-back triple with a one-cycle valid pulse.
module mem_lsu #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input logic         clk,
    input logic         rst,
    mem_lsu_if.slave    bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [15:0] LAT = 16'(MEM_LAT);

    logic [1:0]        state;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sdata_q;
    logic [4:0]        wd_q;
    logic              wreg_q;
    logic [1:0]        byte_k;
    logic [15:0]       cyc;
    logic [31:0]       ld_buf;

    logic              out_valid_r;
    logic [4:0]        wd_r;
    logic              wreg_r;
    logic [31:0]       wdata_r;
    logic [ADDR_W-1:0] mem_a_r;
    logic              mem_wr_r;
    logic [7:0]        mem_dout_r;

    logic [2:0]        nbytes;
    logic              is_store;
    logic              req_mem;
    logic [1:0]        next_k;
    logic              last_issue;
    logic [15:0]       lat_idx;
    logic              sample_now;
    logic              last_sample;
    logic [31:0]       ld_next;
    logic [31:0]       ld_ext;

    always_comb begin
        nbytes = 3'd4;
        case (op_q)
            OP_LB, OP_LBU, OP_SB: nbytes = 3'd1;
            OP_LH, OP_LHU, OP_SH: nbytes = 3'd2;
            default:              nbytes = 3'd4;
        endcase
    end

    assign is_store   = (op_q >= OP_SB) && (op_q <= OP_SW);
    assign req_mem    = (bus.memop_i >= OP_LB) && (bus.memop_i <= OP_SW);
    assign next_k     = byte_k + 2'd1;
    assign last_issue = ({1'b0, byte_k} == (nbytes - 3'd1));

    // cyc counts cycles since acceptance; the byte addressed in cycle j arrives in cycle j+MEM_LAT
    assign lat_idx     = cyc - LAT;
    assign sample_now  = (state != ST_IDLE) && !is_store && (cyc >= LAT) &&
                         (lat_idx < {13'd0, nbytes});
    assign last_sample = sample_now && (lat_idx == ({13'd0, nbytes} - 16'd1));

    always_comb begin
        ld_next = ld_buf;
        if (sample_now)
            ld_next[{lat_idx[1:0], 3'b000} +: 8] = bus.mem_din_i;
    end

    always_comb begin
        ld_ext = ld_next;
        case (op_q)
            OP_LB:   ld_ext = {{24{ld_next[7]}}, ld_next[7:0]};
            OP_LH:   ld_ext = {{16{ld_next[15]}}, ld_next[15:0]};
            OP_LBU:  ld_ext = {24'd0, ld_next[7:0]};
            OP_LHU:  ld_ext = {16'd0, ld_next[15:0]};
            default: ld_ext = ld_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            byte_k      <= '0;
            cyc         <= '0;
            ld_buf      <= '0;
            out_valid_r <= 1'b0;
            wd_r        <= '0;
            wreg_r      <= 1'b0;
            wdata_r     <= '0;
            mem_a_r     <= '0;
            mem_wr_r    <= 1'b0;
            mem_dout_r  <= '0;
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid_i) begin
                        op_q    <= bus.memop_i;
                        addr_q  <= bus.addr_i;
                        sdata_q <= bus.sdata_i;
                        wd_q    <= bus.wd_i;
                        wreg_q  <= bus.wreg_i;
                        byte_k  <= '0;
                        cyc     <= '0;
                        ld_buf  <= '0;
                        if (req_mem) begin
                            state      <= ST_ISSUE;
                            mem_a_r    <= bus.addr_i;
                            mem_wr_r   <= (bus.memop_i >= OP_SB);
                            mem_dout_r <= bus.sdata_i[7:0];
                        end else begin
                            out_valid_r <= 1'b1;
                            wd_r        <= bus.wd_i;
                            wreg_r      <= bus.wreg_i;
                            wdata_r     <= bus.wdata_i;
                        end
                    end
                end
                ST_ISSUE: begin
                    cyc    <= cyc + 16'd1;
                    ld_buf <= ld_next;
                    if (last_issue) begin
                        mem_a_r    <= '0;
                        mem_wr_r   <= 1'b0;
                        mem_dout_r <= '0;
                        if (is_store) begin
                            state       <= ST_IDLE;
                            out_valid_r <= 1'b1;
                            wd_r        <= wd_q;
                            wreg_r      <= 1'b0;
                            wdata_r     <= '0;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        byte_k     <= next_k;
                        mem_a_r    <= addr_q + ADDR_W'(next_k);
                        mem_dout_r <= sdata_q[{next_k, 3'b000} +: 8];
                    end
                end
                ST_DRAIN: begin
                    cyc    <= cyc + 16'd1;
                    ld_buf <= ld_next;
                    if (last_sample) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b1;
                        wd_r        <= wd_q;
                        wreg_r      <= wreg_q;
                        wdata_r     <= ld_ext;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_o     = (state == ST_IDLE) && !rst;
    assign bus.out_valid_o = out_valid_r;
    assign bus.wd_o        = wd_r;
    assign bus.wreg_o      = wreg_r;
    assign bus.wdata_o     = wdata_r;
    assign bus.mem_a_o     = mem_a_r;
    assign bus.mem_wr_o    = mem_wr_r;
    assign bus.mem_dout_o  = mem_dout_r;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: two instances (read latency 1 and 3) share one request stream,
// each with its own RAM, checked against a byte-array reference of memory and timing.
module tb_mem_lsu;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  memop = '0;
    logic [31:0] addr = '0;
    logic [31:0] sdata = '0;
    logic [4:0]  wd = '0;
    logic        wreg = 1'b0;
    logic [31:0] wdata = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_lsu_if #(.ADDR_W(32)) bus0 ();
    mem_lsu_if #(.ADDR_W(32)) bus1 ();

    mem_lsu #(.ADDR_W(32), .MEM_LAT(LAT0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_lsu #(.ADDR_W(32), .MEM_LAT(LAT1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [1:0]  rdy, ov, wrg, mwr;
    logic [4:0]  wdo  [2];
    logic [31:0] wdat [2];
    logic [31:0] ma   [2];
    logic [7:0]  mdo  [2];
    logic [7:0]  dpipe [2][4];
    logic [7:0]  ram [2][512] = '{default: 8'h00};
    logic [7:0]  ref_mem [512] = '{default: 8'h00};

    assign bus0.in_valid_i = in_valid;
    assign bus0.memop_i    = memop;
    assign bus0.addr_i     = addr;
    assign bus0.sdata_i    = sdata;
    assign bus0.wd_i       = wd;
    assign bus0.wreg_i     = wreg;
    assign bus0.wdata_i    = wdata;
    assign bus0.mem_din_i  = dpipe[0][LAT0-1];
    assign bus1.in_valid_i = in_valid;
    assign bus1.memop_i    = memop;
    assign bus1.addr_i     = addr;
    assign bus1.sdata_i    = sdata;
    assign bus1.wd_i       = wd;
    assign bus1.wreg_i     = wreg;
    assign bus1.wdata_i    = wdata;
    assign bus1.mem_din_i  = dpipe[1][LAT1-1];

    assign rdy     = {bus1.ready_o, bus0.ready_o};
    assign ov      = {bus1.out_valid_o, bus0.out_valid_o};
    assign wrg     = {bus1.wreg_o, bus0.wreg_o};
    assign mwr     = {bus1.mem_wr_o, bus0.mem_wr_o};
    assign wdo[0]  = bus0.wd_o;
    assign wdo[1]  = bus1.wd_o;
    assign wdat[0] = bus0.wdata_o;
    assign wdat[1] = bus1.wdata_o;
    assign ma[0]   = bus0.mem_a_o;
    assign ma[1]   = bus1.mem_a_o;
    assign mdo[0]  = bus0.mem_dout_o;
    assign mdo[1]  = bus1.mem_dout_o;

    // RAM model: 512-byte window indexed by the low address bits, read data delayed through dpipe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            dpipe[g][0] <= ram[g][ma[g][8:0]];
            for (int i = 1; i < 4; i++) dpipe[g][i] <= dpipe[g][i-1];
            if (mwr[g] === 1'b1) ram[g][ma[g][8:0]] <= mdo[g];
        end
    end

    int          res_cnt [2];
    int          res_cyc [2][64];
    logic [31:0] res_data [2][64];
    logic [4:0]  res_wd [2][64];
    logic        res_wreg [2][64];
    int          wr_cnt [2];
    int          wr_cyc [2][64];
    logic [31:0] wr_addr [2][64];
    logic [7:0]  wr_data [2][64];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ov[g] === 1'b1) begin
                res_cyc[g][res_cnt[g] % 64]  <= cyc;
                res_data[g][res_cnt[g] % 64] <= wdat[g];
                res_wd[g][res_cnt[g] % 64]   <= wdo[g];
                res_wreg[g][res_cnt[g] % 64] <= wrg[g];
                res_cnt[g] <= res_cnt[g] + 1;
            end
            if (mwr[g] === 1'b1) begin
                wr_cyc[g][wr_cnt[g] % 64]  <= cyc;
                wr_addr[g][wr_cnt[g] % 64] <= ma[g];
                wr_data[g][wr_cnt[g] % 64] <= mdo[g];
                wr_cnt[g] <= wr_cnt[g] + 1;
            end
        end
    end

    function automatic int nbytes_of(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 1;
            4'd2, 4'd5, 4'd7: return 2;
            4'd3, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] v;
        logic [31:0] ba;
        v = 0;
        for (int i = 0; i < nbytes_of(op); i++) begin
            ba = a + 32'(i);
            v = v + (32'(ref_mem[ba[8:0]]) << (8 * i));
        end
        if (op == 4'd1 && v >= 32'h80)   v = v - 32'h100;
        if (op == 4'd2 && v >= 32'h8000) v = v - 32'h10000;
        return v;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                                  input logic [4:0] wdv, input logic wr, input logic [31:0] wdt);
        memop = op; addr = a; sdata = sd; wd = wdv; wreg = wr; wdata = wdt;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] wdv, input logic wr, input logic [31:0] wdt);
        int n, start, ecyc, idx;
        int r0 [2];
        int w0 [2];
        logic is_ld, is_st;
        logic [31:0] edata, ba;
        n = nbytes_of(op);
        is_st = (op >= 4'd6) && (op <= 4'd8);
        is_ld = (n > 0) && !is_st;
        edata = is_ld ? ref_load(op, a) : (is_st ? 32'd0 : wdt);
        check_output("ready_before", 64'(rdy), 64'd3);
        for (int g = 0; g < 2; g++) begin r0[g] = res_cnt[g]; w0[g] = wr_cnt[g]; end
        apply_stimulus(op, a, sd, wdv, wr, wdt);
        start = cyc;
        // requests while both units are busy must be dropped, and latched inputs must not move
        if (is_ld || n >= 2) begin
            memop = 4'($urandom); addr = $urandom; sdata = $urandom; wdata = $urandom;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        repeat (n + 6) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            ecyc = start + (is_ld ? n + (g == 0 ? LAT0 : LAT1) : (is_st ? n : 0));
            idx = r0[g] % 64;
            check_output($sformatf("res_count%0d", g), 64'(res_cnt[g] - r0[g]), 64'd1);
            check_output($sformatf("res_cycle%0d", g), 64'(res_cyc[g][idx]), 64'(ecyc));
            check_output($sformatf("wdata%0d op%0d", g, op), 64'(res_data[g][idx]), 64'(edata));
            check_output($sformatf("wd%0d", g), 64'(res_wd[g][idx]), 64'(wdv));
            check_output($sformatf("wreg%0d", g), 64'(res_wreg[g][idx]), 64'(is_st ? 1'b0 : wr));
            check_output($sformatf("wr_count%0d", g), 64'(wr_cnt[g] - w0[g]), 64'(is_st ? n : 0));
            if (is_st) begin
                for (int k = 0; k < n; k++) begin
                    idx = (w0[g] + k) % 64;
                    check_output($sformatf("write%0d_%0d", g, k),
                                 {wr_addr[g][idx], wr_data[g][idx], 24'(wr_cyc[g][idx])},
                                 {a + 32'(k), sd[8*k +: 8], 24'(start + k)});
                end
            end
        end
        if (is_st) begin
            for (int k = 0; k < n; k++) begin
                ba = a + 32'(k);
                ref_mem[ba[8:0]] = sd[8*k +: 8];
            end
        end
    endtask

    initial begin
        int s, r0 [2], w0 [2];
        logic [3:0]  rop;
        logic [31:0] ra, ba;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check_output($sformatf("rst_regs%0d", g),
                         {22'd0, ov[g], wrg[g], mwr[g], wdo[g], mdo[g], 26'd0},
                         64'd0);
            check_output($sformatf("rst_data%0d", g), {wdat[g], ma[g]}, 64'd0);
        end
        check_output("rst_ready_low", 64'(rdy), 64'd0);
        rst = 1'b0;
        #1;
        check_output("rst_ready", 64'(rdy), 64'd3);

        // three back-to-back NONE requests
        for (int g = 0; g < 2; g++) r0[g] = res_cnt[g];
        memop = 4'd0; wd = 5'd9; wreg = 1'b1; wdata = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        wdata = 32'd2;
        @(posedge clk); #1;
        wdata = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check_output($sformatf("none_count%0d", g), 64'(res_cnt[g] - r0[g]), 64'd3);
            for (int i = 0; i < 3; i++)
                check_output($sformatf("none%0d_%0d", g, i),
                             {res_data[g][(r0[g] + i) % 64], 32'(res_cyc[g][(r0[g] + i) % 64])},
                             {32'(i + 1), 32'(s + i)});
        end

        // directed stores and loads
        run_op(4'd8, 32'h0000_0100, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'h0);
        run_op(4'd3, 32'h0000_0100, 32'h0, 5'd4, 1'b1, 32'h0);
        run_op(4'd1, 32'h0000_0100, 32'h0, 5'd5, 1'b1, 32'h0);
        run_op(4'd4, 32'h0000_0100, 32'h0, 5'd6, 1'b1, 32'h0);
        run_op(4'd2, 32'h0000_0102, 32'h0, 5'd7, 1'b1, 32'h0);
        run_op(4'd7, 32'hFFFF_FFFF, 32'h0000_1234, 5'd8, 1'b1, 32'h0);
        run_op(4'd5, 32'hFFFF_FFFF, 32'h0, 5'd10, 1'b1, 32'h0);
        run_op(4'd3, 32'h0000_0100, 32'h0, 5'd11, 1'b0, 32'h0);

        // reset during the second byte of a word store
        for (int g = 0; g < 2; g++) begin r0[g] = res_cnt[g]; w0[g] = wr_cnt[g]; end
        apply_stimulus(4'd8, 32'h0000_0140, 32'hA5C3_5A3C, 5'd12, 1'b1, 32'h0);
        s = cyc;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("abort_wr", 64'(mwr), 64'd0);
        rst = 1'b0;
        #1;
        check_output("abort_ready", 64'(rdy), 64'd3);
        repeat (6) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check_output($sformatf("abort_res%0d", g), 64'(res_cnt[g] - r0[g]), 64'd0);
            check_output($sformatf("abort_wrs%0d", g), 64'(wr_cnt[g] - w0[g]), 64'd2);
            check_output($sformatf("abort_w1_%0d", g),
                         {wr_addr[g][(w0[g] + 1) % 64], wr_data[g][(w0[g] + 1) % 64],
                          24'(wr_cyc[g][(w0[g] + 1) % 64])},
                         {32'h0000_0141, 8'h5A, 24'(s + 1)});
        end
        ref_mem[9'h140] = 8'h3C;
        ref_mem[9'h141] = 8'h5A;

        // randomized mix, including addresses that wrap past all-ones
        for (int t = 0; t < 40; t++) begin
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           ra = 32'h0000_0100 + 32'($urandom_range(0, 127));
            run_op(rop, ra, $urandom, 5'($urandom), 1'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
